// File: rtl/spi_cmd_scheduler_if.sv
// Host command / RX return port and the spi_top request/completion port of the scheduler.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface spi_cmd_scheduler_if #(
    parameter int SPI_TRF_BIT = 8,
    parameter int CMD_DEPTH   = 8,
    parameter int RX_DEPTH    = 8
);
    // cmd_valid/cmd_ready and rx_valid/rx_ready: a transfer happens in a cycle where both
    // are high at the rising clk edge; valid must not depend combinationally on ready.
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [1:0]                       cmd_req;
    logic [SPI_TRF_BIT-1:0]           cmd_data;
    logic [7:0]                       cmd_wait;
    logic                             rx_valid;
    logic                             rx_ready;
    logic [SPI_TRF_BIT-1:0]           rx_data;
    logic [1:0]                       spi_req;
    logic [SPI_TRF_BIT-1:0]           spi_din;
    logic [7:0]                       spi_wait;
    logic [SPI_TRF_BIT-1:0]           spi_dout;
    logic                             spi_done_tx;
    logic                             spi_done_rx;
    logic                             busy;
    logic                             timeout_err;
    logic                             err_clr;
    logic [$clog2(CMD_DEPTH):0]       cmd_count;
    logic [$clog2(RX_DEPTH):0]        rx_count;

    modport master (
        input  cmd_valid, cmd_req, cmd_data, cmd_wait, rx_ready,
        input  spi_dout, spi_done_tx, spi_done_rx, err_clr,
        output cmd_ready, rx_valid, rx_data, spi_req, spi_din, spi_wait,
        output busy, timeout_err, cmd_count, rx_count
    );

    modport slave (
        output cmd_valid, cmd_req, cmd_data, cmd_wait, rx_ready,
        output spi_dout, spi_done_tx, spi_done_rx, err_clr,
        input  cmd_ready, rx_valid, rx_data, spi_req, spi_din, spi_wait,
        input  busy, timeout_err, cmd_count, rx_count
    );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Buffers host SPI commands, issues them one at a time to spi_top, collects RX words
// into a host-side FIFO and aborts transfers that never signal completion.
module spi_cmd_scheduler #(
    parameter int SPI_TRF_BIT = 8,
    parameter int CMD_DEPTH   = 8,
    parameter int RX_DEPTH    = 8,
    parameter int TIMEOUT     = 65535
) (
    input  logic               clk,
    input  logic               rst,
    spi_cmd_scheduler_if.master bus,
    output logic [1:0]         o_dbg_state
);
    localparam int CAW   = $clog2(CMD_DEPTH);
    localparam int CCW   = CAW + 1;
    localparam int RAW   = $clog2(RX_DEPTH);
    localparam int RCW   = RAW + 1;
    localparam int CMD_W = 2 + SPI_TRF_BIT + 8;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_GAP = 2'd2} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CMD_W-1:0]       r_cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]         r_cmd_wr, r_cmd_rd;
    logic [CCW-1:0]         r_cmd_cnt, w_cmd_cnt_nxt;
    logic                   w_cmd_full, w_cmd_empty, w_cmd_push, w_cmd_pop;
    logic [1:0]             w_head_req;
    logic [SPI_TRF_BIT-1:0] w_head_data;
    logic [7:0]             w_head_wait;
    logic [SPI_TRF_BIT-1:0] r_rx_mem [RX_DEPTH];
    logic [RAW-1:0]         r_rx_wr, r_rx_rd;
    logic [RCW-1:0]         r_rx_cnt;
    logic                   w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic [1:0]             r_spi_req;
    logic [SPI_TRF_BIT-1:0] r_spi_din;
    logic [7:0]             r_spi_wait;
    logic                   r_got_tx, r_got_rx, r_gap_cnt, r_timeout_err, r_busy;
    logic [15:0]            r_tmo_cnt;
    logic                   w_start, w_done, w_abort;

    assign w_cmd_full    = (r_cmd_cnt == CCW'(CMD_DEPTH));
    assign w_cmd_empty   = (r_cmd_cnt == '0);
    assign w_cmd_push    = bus.cmd_valid && !w_cmd_full;
    assign w_cmd_cnt_nxt = r_cmd_cnt + CCW'(w_cmd_push) - CCW'(w_cmd_pop);
    assign {w_head_req, w_head_data, w_head_wait} = r_cmd_mem[r_cmd_rd];

    assign w_rx_full  = (r_rx_cnt == RCW'(RX_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_pop   = bus.rx_ready && !w_rx_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_rx_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cmd_empty) begin
                    if (w_head_req == 2'b00) begin
                        w_cmd_pop = 1'b1;
                    end else if (!(w_head_req[1] && w_rx_full)) begin
                        w_cmd_pop   = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                // Only RX-bearing commands push, so the start-time full check prevents overflow.
                w_rx_push = bus.spi_done_rx && !r_got_rx && r_spi_req[1];
                w_done    = (!r_spi_req[0] || r_got_tx || bus.spi_done_tx) &&
                            (!r_spi_req[1] || r_got_rx || bus.spi_done_rx);
                w_abort   = !w_done && (r_tmo_cnt == 16'(TIMEOUT - 1));
                if (w_done || w_abort) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_spi_req     <= 2'b00;
            r_spi_din     <= '0;
            r_spi_wait    <= '0;
            r_got_tx      <= 1'b0;
            r_got_rx      <= 1'b0;
            r_tmo_cnt     <= '0;
            r_gap_cnt     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_spi_req  <= w_head_req;
                r_spi_din  <= w_head_data;
                r_spi_wait <= w_head_wait;
                r_got_tx   <= 1'b0;
                r_got_rx   <= 1'b0;
                r_tmo_cnt  <= '0;
            end else if (w_state_nxt != S_ACTIVE) begin
                r_spi_req <= 2'b00;
            end
            if (r_state == S_ACTIVE) begin
                if (bus.spi_done_tx) r_got_tx <= 1'b1;
                if (bus.spi_done_rx) r_got_rx <= 1'b1;
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            r_gap_cnt <= (r_state == S_GAP) ? !r_gap_cnt : 1'b0;
            if (w_abort) r_timeout_err <= 1'b1;
            else if (bus.err_clr) r_timeout_err <= 1'b0;
            r_busy <= (w_state_nxt != S_IDLE) || (w_cmd_cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_wr  <= '0;
            r_cmd_rd  <= '0;
            r_cmd_cnt <= '0;
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + CAW'(1);
            if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + CAW'(1);
            r_cmd_cnt <= w_cmd_cnt_nxt;
            if (w_rx_push) r_rx_wr <= r_rx_wr + RAW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + RAW'(1);
            r_rx_cnt <= r_rx_cnt + RCW'(w_rx_push) - RCW'(w_rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wr] <= {bus.cmd_req, bus.cmd_data, bus.cmd_wait};
        if (w_rx_push)  r_rx_mem[r_rx_wr]   <= bus.spi_dout;
    end

    assign bus.cmd_ready   = !w_cmd_full;
    assign bus.rx_valid    = !w_rx_empty;
    assign bus.rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
    assign bus.spi_req     = r_spi_req;
    assign bus.spi_din     = r_spi_din;
    assign bus.spi_wait    = r_spi_wait;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.cmd_count   = r_cmd_cnt;
    assign bus.rx_count    = r_rx_cnt;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: spi_top is modelled by hand-placed done pulses.
module tb_spi_cmd_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;

    spi_cmd_scheduler_if #(.SPI_TRF_BIT(8), .CMD_DEPTH(8), .RX_DEPTH(8)) bus ();

    spi_cmd_scheduler #(
        .SPI_TRF_BIT(8), .CMD_DEPTH(8), .RX_DEPTH(8), .TIMEOUT(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] req, input logic [7:0] data, input logic [7:0] wt);
        bus.cmd_valid = 1'b1;
        bus.cmd_req   = req;
        bus.cmd_data  = data;
        bus.cmd_wait  = wt;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_req = 0; bus.cmd_data = 0; bus.cmd_wait = 0;
        bus.rx_ready = 0; bus.spi_dout = 0; bus.spi_done_tx = 0; bus.spi_done_rx = 0;
        bus.err_clr = 0;

        // Reset values
        tick(); tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_spi_req", bus.spi_req, 0);
        chk("rst_spi_din", bus.spi_din, 0);
        chk("rst_spi_wait", bus.spi_wait, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_cmd_count", bus.cmd_count, 0);
        chk("rst_rx_count", bus.rx_count, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // Full duplex {11, A5, 4}: done_tx at S+20, done_rx at S+25
        push_cmd(2'b11, 8'hA5, 8'd4);
        chk("fd_cnt_n1", bus.cmd_count, 1);
        chk("fd_busy_n1", bus.busy, 1);
        chk("fd_req_n1", bus.spi_req, 0);
        tick();
        chk("fd_req_s", bus.spi_req, 2'b11);
        chk("fd_din_s", bus.spi_din, 8'hA5);
        chk("fd_wait_s", bus.spi_wait, 8'd4);
        chk("fd_cnt_s", bus.cmd_count, 0);
        chk("fd_state_s", dbg_state, 1);
        repeat (20) tick();
        bus.spi_done_tx = 1'b1;
        chk("fd_req_s20", bus.spi_req, 2'b11);
        tick();
        bus.spi_done_tx = 1'b0;
        chk("fd_req_s21", bus.spi_req, 2'b11);
        repeat (4) tick();
        bus.spi_done_rx = 1'b1;
        bus.spi_dout    = 8'h3C;
        chk("fd_req_s25", bus.spi_req, 2'b11);
        chk("fd_rxcnt_s25", bus.rx_count, 0);
        tick();
        bus.spi_done_rx = 1'b0;
        bus.spi_dout    = 8'h00;
        chk("fd_req_s26", bus.spi_req, 0);
        chk("fd_rxdata_s26", bus.rx_data, 8'h3C);
        chk("fd_rxcnt_s26", bus.rx_count, 1);
        chk("fd_rxvalid_s26", bus.rx_valid, 1);
        tick();
        chk("fd_req_s27", bus.spi_req, 0);
        chk("fd_state_s27", dbg_state, 2);
        tick();
        chk("fd_state_s28", dbg_state, 0);
        chk("fd_busy_s28", bus.busy, 0);
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        chk("fd_pop_cnt", bus.rx_count, 0);
        chk("fd_pop_valid", bus.rx_valid, 0);
        chk("fd_pop_data", bus.rx_data, 0);

        // Nine TX pushes back-to-back: the first starts at once, the other eight fill the FIFO
        for (int i = 0; i < 9; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_req   = 2'b01;
            bus.cmd_data  = 8'h10 + 8'(i);
            bus.cmd_wait  = 8'd1;
            tick();
        end
        bus.cmd_data = 8'hEE;
        chk("full_ready", bus.cmd_ready, 0);
        chk("full_cnt", bus.cmd_count, 8);
        tick();
        bus.cmd_valid = 1'b0;
        chk("full_cnt_after", bus.cmd_count, 8);
        chk("full_busy", bus.busy, 1);
        for (int i = 0; i < 9; i++) begin
            chk("tx_req", bus.spi_req, 2'b01);
            chk("tx_din", bus.spi_din, 8'h10 + 8'(i));
            bus.spi_done_tx = 1'b1;
            tick();
            bus.spi_done_tx = 1'b0;
            chk("tx_gap1", bus.spi_req, 0);
            tick();
            chk("tx_gap2", bus.spi_req, 0);
            tick();
            chk("tx_idle", bus.spi_req, 0);
            tick();
        end
        chk("tx_end_req", bus.spi_req, 0);
        chk("tx_end_cnt", bus.cmd_count, 0);
        chk("tx_end_busy", bus.busy, 0);

        // No-op between two TX commands
        push_cmd(2'b01, 8'h55, 8'd0);
        push_cmd(2'b00, 8'h00, 8'd0);
        push_cmd(2'b01, 8'h66, 8'd0);
        chk("nop_req1", bus.spi_req, 2'b01);
        chk("nop_din1", bus.spi_din, 8'h55);
        chk("nop_cnt1", bus.cmd_count, 2);
        bus.spi_done_tx = 1'b1;
        tick();
        bus.spi_done_tx = 1'b0;
        tick(); tick(); tick();
        chk("nop_req_m4", bus.spi_req, 0);
        chk("nop_cnt_m4", bus.cmd_count, 1);
        tick();
        chk("nop_req2", bus.spi_req, 2'b01);
        chk("nop_din2", bus.spi_din, 8'h66);
        chk("nop_cnt2", bus.cmd_count, 0);
        bus.spi_done_tx = 1'b1;
        tick();
        bus.spi_done_tx = 1'b0;
        tick(); tick(); tick();

        // Fill the RX FIFO with eight RX-only transfers
        for (int i = 0; i < 8; i++) begin
            push_cmd(2'b10, 8'h00, 8'd0);
            tick();
            chk("fill_req", bus.spi_req, 2'b10);
            bus.spi_done_rx = 1'b1;
            bus.spi_dout    = 8'h80 + 8'(i);
            tick();
            bus.spi_done_rx = 1'b0;
            tick(); tick();
        end
        chk("fill_rxcnt", bus.rx_count, 8);
        chk("fill_head", bus.rx_data, 8'h80);
        push_cmd(2'b10, 8'h00, 8'd7);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", bus.spi_req, 0);
            chk("stall_cnt", bus.cmd_count, 1);
            tick();
        end
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        chk("stall_pop_rxcnt", bus.rx_count, 7);
        chk("stall_pop_head", bus.rx_data, 8'h81);
        chk("stall_pop_req", bus.spi_req, 0);
        tick();
        chk("stall_start_req", bus.spi_req, 2'b10);
        chk("stall_start_wait", bus.spi_wait, 8'd7);
        chk("stall_start_cnt", bus.cmd_count, 0);
        bus.spi_done_rx = 1'b1;
        bus.spi_dout    = 8'h99;
        tick();
        bus.spi_done_rx = 1'b0;
        chk("stall_rxcnt", bus.rx_count, 8);
        bus.rx_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_data", bus.rx_data, (j < 7) ? 32'h81 + 32'(j) : 32'h99);
            tick();
        end
        bus.rx_ready = 1'b0;
        chk("drain_cnt", bus.rx_count, 0);
        chk("drain_valid", bus.rx_valid, 0);

        // Timeout: full duplex with done_tx only
        push_cmd(2'b11, 8'h77, 8'd0);
        tick();
        repeat (5) tick();
        bus.spi_done_tx = 1'b1;
        tick();
        bus.spi_done_tx = 1'b0;
        repeat (25) tick();
        chk("tmo_err_s31", bus.timeout_err, 0);
        chk("tmo_req_s31", bus.spi_req, 2'b11);
        tick();
        chk("tmo_err_s32", bus.timeout_err, 1);
        chk("tmo_req_s32", bus.spi_req, 0);
        chk("tmo_rxcnt", bus.rx_count, 0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("tmo_clr", bus.timeout_err, 0);
        tick();
        bus.spi_done_rx = 1'b1;
        bus.spi_done_tx = 1'b1;
        bus.spi_dout    = 8'h55;
        tick();
        bus.spi_done_rx = 1'b0;
        bus.spi_done_tx = 1'b0;
        chk("idle_done_rxcnt", bus.rx_count, 0);
        chk("idle_done_state", dbg_state, 0);
        push_cmd(2'b10, 8'h00, 8'd0);
        tick();
        repeat (31) tick();
        bus.err_clr = 1'b1;
        chk("tmo2_req_s31", bus.spi_req, 2'b10);
        tick();
        bus.err_clr = 1'b0;
        chk("tmo2_set_wins", bus.timeout_err, 1);
        chk("tmo2_rxcnt", bus.rx_count, 0);
        chk("tmo2_req", bus.spi_req, 0);
        tick(); tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("tmo2_clr", bus.timeout_err, 0);

        // Reset during ACTIVE with three commands queued
        push_cmd(2'b10, 8'h00, 8'd0);
        tick();
        bus.spi_done_rx = 1'b1;
        bus.spi_dout    = 8'hAB;
        tick();
        bus.spi_done_rx = 1'b0;
        tick(); tick();
        chk("prerst_rxcnt", bus.rx_count, 1);
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_req   = 2'b01;
            bus.cmd_data  = 8'hC0 + 8'(i);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("prerst_cnt", bus.cmd_count, 3);
        chk("prerst_req", bus.spi_req, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_req", bus.spi_req, 0);
        chk("midrst_cnt", bus.cmd_count, 0);
        chk("midrst_rxcnt", bus.rx_count, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.cmd_ready, 1);
        chk("midrst_rxvalid", bus.rx_valid, 0);
        tick();
        chk("postrst_req", bus.spi_req, 0);
        chk("postrst_state", dbg_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_cmd_scheduler.md
# spi_cmd_scheduler

Command scheduler upstream of `spi_top`. Buffers host SPI commands (request type, TX byte, CS wait duration) in a command FIFO, presents them one at a time on the `spi_top` `req`/`din_master`/`wait_duration` inputs, and waits for `done_tx`/`done_rx`. Received `dout_master` words go into an RX FIFO for the host. A timeout guards against a transfer that never completes.

## Interface

Parameters:
- `SPI_TRF_BIT`, 8: data word width; matches `spi_top`.
- `CMD_DEPTH`, 8: command FIFO entries; power of 2, ≥2.
- `RX_DEPTH`, 8: RX FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 65535: max clk cycles in ACTIVE before abort; 16-bit counter, ≥1.

Ports:
- `clk` in 1: single system clock, same clock as `spi_top`.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: `!cmd_full`.
- `cmd_req` in 2: 01 TX only, 10 RX only, 11 full duplex, 00 no-op.
- `cmd_data` in SPI_TRF_BIT: TX word.
- `cmd_wait` in 8: CS wait duration.
- `rx_valid` out 1: RX FIFO non-empty.
- `rx_ready` in 1: host pop.
- `rx_data` out SPI_TRF_BIT: RX FIFO head, valid while `rx_valid`.
- `spi_req` out 2: to `spi_top.req`.
- `spi_din` out SPI_TRF_BIT: to `din_master`.
- `spi_wait` out 8: to `wait_duration`.
- `spi_dout` in SPI_TRF_BIT: from `dout_master`.
- `spi_done_tx` in 1: from `done_tx`, 1-cycle pulse.
- `spi_done_rx` in 1: from `done_rx`, 1-cycle pulse; `spi_dout` valid in the same cycle.
- `busy` out 1: state ≠ IDLE or command FIFO non-empty.
- `timeout_err` out 1: sticky; set on abort.
- `err_clr` in 1: clears `timeout_err`.
- `cmd_count` out $clog2(CMD_DEPTH)+1: command FIFO occupancy.
- `rx_count` out $clog2(RX_DEPTH)+1: RX FIFO occupancy.

## Operation

- Command FIFO: a write occurs when `cmd_valid & cmd_ready`. The write is refused when full, even if a pop happens in the same cycle.
- RX FIFO: push and pop in the same cycle are allowed. When empty, a pop is ignored. Overflow cannot occur; see the start rule below.
- FSM states:
  - **IDLE**: if the command FIFO is non-empty, inspect the head.
    - `cmd_req`=00: pop and discard, stay in IDLE.
    - `cmd_req[1]`=1 and RX FIFO full: stall without popping.
    - Otherwise: pop, load `spi_din`/`spi_wait`/`spi_req` registers, clear sticky flags `got_tx`/`got_rx` and the timeout counter, go to ACTIVE.
  - **ACTIVE**: `spi_req` holds the command value; `spi_din`/`spi_wait` are stable.
    - Set `got_tx` on `spi_done_tx`, `got_rx` on `spi_done_rx`.
    - On `spi_done_rx`, push `spi_dout` into the RX FIFO (at most one push per command; further pulses are ignored).
    - Completion condition: (`got_tx` or pulse) for `req[0]`, AND (`got_rx` or pulse) for `req[1]`. Pulses may arrive in any order or together. On completion go to GAP.
    - The counter increments each ACTIVE cycle. When it reaches TIMEOUT without completion: set `timeout_err`, go to GAP. No RX push occurs unless `done_rx` was already seen.
  - **GAP**: `spi_req`=00 for exactly 2 cycles, then IDLE. The gap lets `spi_master` return to idle.
- `spi_req` is 00 in every state except ACTIVE.
- Done pulses arriving outside ACTIVE are ignored.
- `err_clr` and a new timeout in the same cycle: set wins.

## Timing

- Reset values: `cmd_ready`=1, `rx_valid`=0, `rx_data`=0, `spi_req`=00, `spi_din`=0, `spi_wait`=0, `busy`=0, `timeout_err`=0, `cmd_count`=0, `rx_count`=0, FSM in IDLE.
- `rst` mid-transfer: both FIFOs are flushed and `spi_req` drops to 00 the next cycle. `spi_top` shares `rst`.
- Command accepted at cycle N with FSM in IDLE and FIFO empty: `cmd_count`=1 at N+1; pop at N+1; `spi_req` valid from N+2.
- Completion detected in cycle M: `spi_req`=00 at M+1 and M+2; IDLE at M+3. The next `spi_req` is valid at M+4 at the earliest.
- RX push in cycle M: `rx_valid`=1 and `rx_count` incremented at M+1.
- Timeout: with `spi_req` first valid at cycle S, abort fires in cycle S+TIMEOUT-1 and `timeout_err`=1 from S+TIMEOUT.
- All outputs are registered except `cmd_ready`, `rx_valid` and `rx_data`, which are decoded from registered FIFO state.

## Test plan

- Full-duplex {11, 0xA5, 4}, then `done_tx` at cycle S+20 and `done_rx`=0x3C at S+25 → `spi_req`=11 from S through S+25; 00 for 2 cycles; `rx_data`=0x3C and `rx_count`=1 at S+26.
- Queue 8 TX-only commands back-to-back; a 9th attempt while full → `cmd_ready`=0 and the 9th is not written. Each command produces one `spi_req`=01 window with the matching `spi_din`, separated by 2-cycle gaps.
- No-op {00} queued between two TX commands → discarded; `spi_req` never shows 00 outside GAP/IDLE; the second TX command starts next.
- RX FIFO full (8 entries) with an RX command queued → `spi_req` stays 00 and `cmd_count` is unchanged. One host pop → the transfer starts 2 cycles later.
- TIMEOUT=16 with no done pulses → `timeout_err`=1 at S+16, `spi_req`=00, no RX push. `err_clr` → `timeout_err`=0 next cycle.
- `rst` pulsed during ACTIVE with 3 commands queued → next cycle `spi_req`=00, `cmd_count`=0, `rx_count`=0, `busy`=0.
